// File: rtl/ps2_kbmat_pkg.sv
// Shared constants, receive FSM states and the PS/2 set-2 to Z88 key matrix
// lookup used by ps2_kbmat and ps2_rx_frame.
package ps2_kbmat_pkg;

  localparam logic [7:0] CODE_E0   = 8'hE0;
  localparam logic [7:0] CODE_F0   = 8'hF0;
  localparam logic [7:0] CODE_E1   = 8'hE1;
  localparam logic [7:0] CODE_AA   = 8'hAA;
  localparam logic [7:0] CODE_FA   = 8'hFA;
  localparam logic [7:0] CODE_OVR0 = 8'h00;
  localparam logic [7:0] CODE_OVRF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Returns {valid, idx}; idx = row*8 + col of the Z88 matrix.
  function automatic logic [6:0] key_lookup(input logic e0, input logic [7:0] code);
    logic [6:0] r;
    r = 7'd0;
    case ({e0, code})
      9'h03E: r = {1'b1, 6'd0};
      9'h03D: r = {1'b1, 6'd1};
      9'h031: r = {1'b1, 6'd2};
      9'h033: r = {1'b1, 6'd3};
      9'h035: r = {1'b1, 6'd4};
      9'h036: r = {1'b1, 6'd5};
      9'h05A: r = {1'b1, 6'd6};
      9'h066: r = {1'b1, 6'd7};
      9'h043: r = {1'b1, 6'd8};
      9'h03C: r = {1'b1, 6'd9};
      9'h032: r = {1'b1, 6'd10};
      9'h034: r = {1'b1, 6'd11};
      9'h02C: r = {1'b1, 6'd12};
      9'h02E: r = {1'b1, 6'd13};
      9'h055: r = {1'b1, 6'd14};
      9'h05D: r = {1'b1, 6'd15};
      9'h044: r = {1'b1, 6'd16};
      9'h03B: r = {1'b1, 6'd17};
      9'h02A: r = {1'b1, 6'd18};
      9'h02B: r = {1'b1, 6'd19};
      9'h02D: r = {1'b1, 6'd20};
      9'h025: r = {1'b1, 6'd21};
      9'h04E: r = {1'b1, 6'd22};
      9'h05B: r = {1'b1, 6'd23};
      9'h046: r = {1'b1, 6'd24};
      9'h042: r = {1'b1, 6'd25};
      9'h021: r = {1'b1, 6'd26};
      9'h023: r = {1'b1, 6'd27};
      9'h024: r = {1'b1, 6'd28};
      9'h026: r = {1'b1, 6'd29};
      9'h054: r = {1'b1, 6'd30};
      9'h052: r = {1'b1, 6'd31};
      9'h045: r = {1'b1, 6'd32};
      9'h04B: r = {1'b1, 6'd33};
      9'h022: r = {1'b1, 6'd34};
      9'h01B: r = {1'b1, 6'd35};
      9'h01D: r = {1'b1, 6'd36};
      9'h01E: r = {1'b1, 6'd37};
      9'h029: r = {1'b1, 6'd38};
      9'h04C: r = {1'b1, 6'd39};
      9'h04D: r = {1'b1, 6'd40};
      9'h041: r = {1'b1, 6'd41};
      9'h01A: r = {1'b1, 6'd42};
      9'h015: r = {1'b1, 6'd43};
      9'h016: r = {1'b1, 6'd44};
      9'h00D: r = {1'b1, 6'd45};
      9'h00E: r = {1'b1, 6'd46};
      9'h04A: r = {1'b1, 6'd47};
      9'h049: r = {1'b1, 6'd48};
      9'h058: r = {1'b1, 6'd49};
      9'h01C: r = {1'b1, 6'd50};
      9'h076: r = {1'b1, 6'd51};
      9'h014: r = {1'b1, 6'd52};
      9'h011: r = {1'b1, 6'd53};
      9'h012: r = {1'b1, 6'd54};
      9'h005: r = {1'b1, 6'd55};
      9'h059: r = {1'b1, 6'd56};
      9'h174: r = {1'b1, 6'd57};
      9'h172: r = {1'b1, 6'd58};
      9'h175: r = {1'b1, 6'd59};
      9'h16B: r = {1'b1, 6'd60};
      9'h171: r = {1'b1, 6'd61};
      9'h006: r = {1'b1, 6'd62};
      9'h004: r = {1'b1, 6'd63};
      default: r = 7'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: pin synchronisers, ps2_clk glitch filter, frame FSM
// and mid-frame timeout. Optional odd-parity check under PS2_PARITY_CHK_EN.
module ps2_rx_frame
  import ps2_kbmat_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 10000
) (
  input  logic       mck,
  input  logic       rin,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       rx_err,
  output logic       flag_clr
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          clk_p0, clk_p1, dat_p0, dat_p1;
  logic          filt_lvl, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_n;
  logic [TW-1:0] to_cnt, to_n;
  logic [7:0]    byte_n;
  logic          vld_n, err_n, clr_n;

  // Stage p0/p1: synchronisers, then the filtered clock level
  always_ff @(posedge mck) begin
    if (rin) begin
      clk_p0    <= 1'b1;
      clk_p1    <= 1'b1;
      dat_p0    <= 1'b1;
      dat_p1    <= 1'b1;
      filt_lvl  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_p0    <= ps2_clk;
      clk_p1    <= clk_p0;
      dat_p0    <= ps2_dat;
      dat_p1    <= dat_p0;
      filt_prev <= filt_lvl;
      if (clk_p1 == filt_lvl) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt_lvl <= clk_p1;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = filt_prev & ~filt_lvl;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_bit;
    byte_n    = rx_byte;
    vld_n     = 1'b0;
    err_n     = 1'b0;
    clr_n     = 1'b0;
    to_n      = '0;
    if (state != ST_IDLE && !fall) to_n = to_cnt + 1'b1;

    case (state)
      ST_IDLE: begin
        if (fall) begin
          if (!dat_p1) begin
            state_n   = ST_DATA;
            bit_cnt_n = 3'd0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (fall) begin
          shreg_n   = {dat_p1, shreg[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_n   = dat_p1;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_n = ST_IDLE;
          if (!dat_p1) begin
            err_n = 1'b1;
`ifdef PS2_PARITY_CHK_EN
          end else if (!(^{shreg, par_bit})) begin
            err_n = 1'b1;
            clr_n = 1'b1;
`endif
          end else begin
            byte_n = shreg;
            vld_n  = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A stalled frame is abandoned and any pending prefixes are dropped
    if (state != ST_IDLE && !fall && to_cnt == TW'(TIMEOUT - 1)) begin
      state_n = ST_IDLE;
      err_n   = 1'b1;
      clr_n   = 1'b1;
      to_n    = '0;
    end
  end

  // Stage p2: frame state and registered byte/valid/error outputs
  always_ff @(posedge mck) begin
    if (rin) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      rx_byte  <= 8'd0;
      rx_vld   <= 1'b0;
      rx_err   <= 1'b0;
      flag_clr <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par_bit  <= par_n;
      to_cnt   <= to_n;
      rx_byte  <= byte_n;
      rx_vld   <= vld_n;
      rx_err   <= err_n;
      flag_clr <= clr_n;
    end
  end

endmodule

// File: rtl/ps2_kbmat.sv
// PS/2 set-2 keyboard to Z88 64-bit key matrix for the Blink row scanner.
// Build option PS2_PARITY_CHK_EN enables odd-parity checking in ps2_rx_frame.
module ps2_kbmat
  import ps2_kbmat_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 10000
) (
  input  logic        mck,
  input  logic        rin,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [63:0] kbmat,
  output logic        key_evt,
  output logic [7:0]  scancode,
  output logic        frame_err
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_err, flag_clr;
  logic       e0, f0;
  logic [2:0] skip;
  logic [6:0] lk;

  ps2_rx_frame #(
    .FILT_LEN(FILT_LEN),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .mck     (mck),
    .rin     (rin),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .rx_byte (rx_byte),
    .rx_vld  (rx_vld),
    .rx_err  (rx_err),
    .flag_clr(flag_clr)
  );

  assign scancode  = rx_byte;
  assign frame_err = rx_err;
  assign lk        = key_lookup(e0, rx_byte);

  // Stage p3: byte decode into the key matrix
  always_ff @(posedge mck) begin
    if (rin) begin
      kbmat   <= 64'd0;
      key_evt <= 1'b0;
      e0      <= 1'b0;
      f0      <= 1'b0;
      skip    <= 3'd0;
    end else begin
      key_evt <= 1'b0;
      if (flag_clr) begin
        e0 <= 1'b0;
        f0 <= 1'b0;
      end else if (rx_vld) begin
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else begin
          case (rx_byte)
            CODE_E0: e0 <= 1'b1;
            CODE_F0: f0 <= 1'b1;
            CODE_E1: skip <= 3'd7;
            CODE_AA, CODE_FA: ;
            CODE_OVR0, CODE_OVRF: begin
              kbmat   <= 64'd0;
              key_evt <= |kbmat;
              e0      <= 1'b0;
              f0      <= 1'b0;
            end
            default: begin
              e0 <= 1'b0;
              f0 <= 1'b0;
              // Bit equal to f0 means the make/break actually changes it
              if (lk[6] && kbmat[lk[5:0]] == f0) begin
                kbmat[lk[5:0]] <= ~f0;
                key_evt        <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbmat.sv
// Randomised scoreboard bench for ps2_kbmat: frames are bit-banged on the
// PS/2 pins, expectations come from a byte-level model of the key protocol.
module tb_ps2_kbmat;

  localparam int HALF = 16;
  localparam int GAP  = 24;

  logic        mck = 1'b0;
  logic        rin = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [63:0] kbmat;
  logic        key_evt;
  logic [7:0]  scancode;
  logic        frame_err;

  int vec = 0;
  int bad = 0;

  logic [63:0] evt_q[$];
  int          err_q[$];
  logic [63:0] m_kb = 64'd0;
  bit          m_e0 = 1'b0;
  bit          m_f0 = 1'b0;
  int          m_skip = 0;
  logic [7:0]  last_sc = 8'h00;

  ps2_kbmat #(.FILT_LEN(8), .TIMEOUT(10000)) dut (
    .mck      (mck),
    .rin      (rin),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .kbmat    (kbmat),
    .key_evt  (key_evt),
    .scancode (scancode),
    .frame_err(frame_err)
  );

  always #5 mck = ~mck;

  initial begin
    #950000;
    $display("FAIL watchdog: simulation still running at 95000 cycles, expected done");
    $fatal(1, "watchdog");
  end

  // Keys the bench knows: Z88 matrix index, or -1 when the key has no entry
  function automatic int kidx(input bit e0, input logic [7:0] code);
    if (e0) begin
      case (code)
        8'h75: return 59;
        8'h6B: return 60;
        default: return -1;
      endcase
    end
    case (code)
      8'h5A: return 6;
      8'h66: return 7;
      8'h29: return 38;
      8'h15: return 43;
      8'h1C: return 50;
      8'h12: return 54;
      default: return -1;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int idx;
    last_sc = b;
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    case (b)
      8'hE0: m_e0 = 1'b1;
      8'hF0: m_f0 = 1'b1;
      8'hE1: m_skip = 7;
      8'hAA, 8'hFA: ;
      8'h00, 8'hFF: begin
        if (m_kb != 64'd0) evt_q.push_back(64'd0);
        m_kb = 64'd0;
        m_e0 = 1'b0;
        m_f0 = 1'b0;
      end
      default: begin
        idx = kidx(m_e0, b);
        if (idx >= 0 && m_kb[idx] != !m_f0) begin
          m_kb[idx] = !m_f0;
          evt_q.push_back(m_kb);
        end
        m_e0 = 1'b0;
        m_f0 = 1'b0;
      end
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge mck);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int nbits,
                            input bit glitch);
    logic [10:0] fr;
    fr = {stop_b, ~^b, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      if (glitch && i == 3) begin
        tick(10);
        ps2_clk = 1'b0;
        tick(4);
        ps2_clk = 1'b1;
        tick(6);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    tick(GAP);
  endtask

  task automatic post_check();
    chk("scancode", {56'd0, scancode}, {56'd0, last_sc});
    chk("evt_pending", 64'(evt_q.size()), 64'd0);
    chk("err_pending", 64'(err_q.size()), 64'd0);
    chk("kbmat", kbmat, m_kb);
  endtask

  task automatic do_byte(input logic [7:0] b, input bit glitch);
    model_byte(b);
    send_frame(b, 1'b1, 11, glitch);
    post_check();
  endtask

  // Monitor: every key_evt / frame_err pulse consumes one expectation
  always @(negedge mck) begin
    if (rin !== 1'b1) begin
      if (key_evt !== 1'b0) begin
        vec++;
        if (evt_q.size() == 0) begin
          bad++;
          $display("FAIL key_evt: unexpected pulse (value %b), kbmat=%h, expected none", key_evt, kbmat);
        end else if (kbmat !== evt_q[0]) begin
          bad++;
          $display("FAIL evt_kbmat: got %h, expected %h", kbmat, evt_q[0]);
          void'(evt_q.pop_front());
        end else begin
          void'(evt_q.pop_front());
        end
      end
      if (frame_err !== 1'b0) begin
        vec++;
        if (err_q.size() == 0) begin
          bad++;
          $display("FAIL frame_err: unexpected pulse (value %b), expected none", frame_err);
        end else begin
          void'(err_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] pool[15];
    logic [7:0] b;
    pool = '{8'h1C, 8'h5A, 8'h12, 8'h29, 8'h15, 8'h66, 8'h75, 8'h6B,
             8'h7E, 8'h01, 8'h1F, 8'hF0, 8'hE0, 8'hAA, 8'hFA};

    tick(5);
    chk("rst_kbmat", kbmat, 64'd0);
    chk("rst_key_evt", {63'd0, key_evt}, 64'd0);
    chk("rst_scancode", {56'd0, scancode}, 64'd0);
    chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
    rin = 1'b0;
    tick(5);

    // Make/break of 'A'
    do_byte(8'h1C, 1'b0);
    do_byte(8'hF0, 1'b0);
    do_byte(8'h1C, 1'b0);

    // Extended cursor up, and the non-extended code that must not touch it
    do_byte(8'hE0, 1'b0);
    do_byte(8'h75, 1'b0);
    chk("up_set", {63'd0, kbmat[59]}, 64'd1);
    do_byte(8'hE0, 1'b0);
    do_byte(8'hF0, 1'b0);
    do_byte(8'h75, 1'b0);
    do_byte(8'h75, 1'b0);
    chk("up_clr", {63'd0, kbmat[59]}, 64'd0);

    // Typematic repeat, second key, overrun clear
    repeat (4) do_byte(8'h5A, 1'b0);
    do_byte(8'h12, 1'b0);
    chk("two_keys", {62'd0, kbmat[54], kbmat[6]}, 64'd3);
    do_byte(8'h00, 1'b0);
    chk("overrun", kbmat, 64'd0);

    // Bad stop bit: error, nothing decoded, then a clean frame
    do_byte(8'h12, 1'b0);
    err_q.push_back(1);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    post_check();
    do_byte(8'h1C, 1'b0);

    // Stalled frame after data bit 4: timeout drops the pending E0
    do_byte(8'hE0, 1'b0);
    err_q.push_back(1);
    m_e0 = 1'b0;
    m_f0 = 1'b0;
    send_frame(8'h5A, 1'b1, 6, 1'b0);
    tick(10100);
    chk("timeout_err", 64'(err_q.size()), 64'd0);
    do_byte(8'h75, 1'b0);

    // Pause sequence is swallowed whole
    do_byte(8'h00, 1'b0);
    do_byte(8'hE1, 1'b0);
    foreach (pool[i]) if (i < 7) do_byte(pool[i], 1'b0);
    do_byte(8'h1C, 1'b0);
    chk("pause_only_a", kbmat, 64'd1 << 50);

    // Short clock glitches, idle and mid-frame
    ps2_clk = 1'b0;
    tick(4);
    ps2_clk = 1'b1;
    tick(GAP);
    do_byte(8'h29, 1'b1);
    chk("glitch_frame", kbmat, (64'd1 << 50) | (64'd1 << 38));

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 19) == 0) b = 8'h00;
      else b = pool[$urandom_range(0, 14)];
      do_byte(b, 1'b0);
    end

    // Reset in the middle of a frame
    do_byte(8'h29, 1'b0);
    do_byte(8'h29, 1'b0);
    send_frame(8'h1C, 1'b1, 6, 1'b0);
    rin = 1'b1;
    tick(3);
    chk("midrst_kbmat", kbmat, 64'd0);
    chk("midrst_key_evt", {63'd0, key_evt}, 64'd0);
    chk("midrst_scancode", {56'd0, scancode}, 64'd0);
    chk("midrst_frame_err", {63'd0, frame_err}, 64'd0);
    m_kb = 64'd0;
    m_e0 = 1'b0;
    m_f0 = 1'b0;
    m_skip = 0;
    evt_q.delete();
    err_q.delete();
    rin = 1'b0;
    tick(5);
    do_byte(8'h1C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
